dsp48e2_alu_model: RTL and testbench
====================================

Name: dsp48e2_alu_model

Overview:
- Synthesizable behavioural model of the DSP48E2 datapath subset used by the ultrascale primitive library (add/sub, 48-bit logic ops, optional 27x18 multiply).
- Single 48-bit lane (ONE48), no pre-adder, no pattern detect, no A/B/C/M pipeline registers; only P is optionally registered.
- Drop-in target for the dsp_* wrappers (e.g. NOR via OPMODE 000111011 / ALUMODE 1110).

Parameters:
- PREG, 0, number of P pipeline stages (0 or 1).
- USE_MULT, 0, 1 enables the 27x18 signed multiplier; 0 forces M=0.
- RND, 48'h0, constant for the W mux.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; clears P register.
- ce_p  in  1  clock enable for P register (PREG=1 only).
- a  in  30  A data; A:B concat uses all bits; multiplier uses a[26:0].
- b  in  18  B data.
- c  in  48  C data.
- pcin  in  48  cascade input.
- carryin  in  1  carry-in (CARRYINSEL=000 semantics only).
- opmode  in  9  [1:0]=X, [3:2]=Y, [6:4]=Z, [8:7]=W.
- alumode  in  4  ALU function.
- p  out  48  result.
- carryout  out  1  adder carry (bit 48).

Behaviour:
- X: 00=0, 01=M, 10=P, 11={a,b} (a in [47:18]).
- Y: 00=0, 01=M, 10=48'hFFFF_FFFF_FFFF, 11=c.
- Z: 000=0, 001=pcin, 010=P, 011=c, 100=P, 101=pcin>>>17, 110=P>>>17, 111=0 (reserved).
- W: 00=0, 01=P, 10=RND, 11=c.
- M = sign-extended signed a[26:0] * signed b[17:0]; contributed once when X=01 and Y=01; X=01 or Y=01 alone, or USE_MULT=0 -> M term 0.
- P feedback uses the P register; when PREG=0 every P selection reads 0 (no combinational loop).
- Arithmetic (49-bit internal, S=W+X+Y+carryin):
  - 0000 Z+S
  - 0011 Z-S
  - 0001 -Z+S-1
  - 0010 ~(Z+S)
- carryout = bit 48 for 0000 and 0011; 0 otherwise.
- Logic (W and carryin ignored, carryout=0):
  - With Y=00: 0100/0110 X^Z; 0101/0111 ~(X^Z); 1100 X&Z; 1101 X&~Z; 1110 ~(X&Z); 1111 ~X|Z.
  - With Y=10: 0100/0110 ~(X^Z); 0101/0111 X^Z; 1100 X|Z; 1101 X|~Z; 1110 ~(X|Z); 1111 ~X&Z.
- Logic ALUMODE with Y=01/11, and any undefined ALUMODE -> result 0.
- PREG=0: p and carryout are combinational, zero latency; clock, reset and ce_p ignored.
- PREG=1: 1-cycle latency.
  - reset=1 at an edge -> p=0, carryout=0; reset has priority over ce_p.
  - ce_p=0 holds.
  - Power-up value 0.
- Width: all arithmetic wraps modulo 2^48.

Test Plan:
- PREG=0, opmode=000111011, alumode=1110, {a,b}=48'h0000_0000_00F0, c=48'h0000_0000_00FF -> p=48'hFFFF_FFFF_FF00 (NOR).
- PREG=0, opmode=000110011, alumode=0000, {a,b}=5, c=7, carryin=1 -> p=13, carryout=0; then c=48'hFFFF_FFFF_FFFF, {a,b}=1, carryin=0 -> p=0, carryout=1.
- PREG=0, alumode=0011, opmode=000110011, c=10, {a,b}=3 -> p=7.
- USE_MULT=1, PREG=1, opmode=000000101, alumode=0000, a[26:0]=-3, b=4, ce_p=1 -> p=-12 (48'hFFFF_FFFF_FFF4) one cycle later.
- PREG=1, accumulate opmode=000100011 (Z=P, X=A:B), {a,b}=1, ce_p=1 for 4 cycles after reset -> p=1,2,3,4; ce_p=0 holds 4; reset=1 -> p=0 next edge.
- PREG=1, reset and ce_p both high with nonzero inputs -> p=0.

Source files
------------

// File: rtl/dsp48e2_alu_model.sv
// Single-lane DSP48E2 datapath subset: W/X/Y/Z muxes, 48-bit add/sub and logic ALU,
// optional 27x18 signed multiplier and optional P output register.
module dsp48e2_alu_model #(
  parameter int unsigned PREG     = 0,
  parameter int unsigned USE_MULT = 0,
  parameter logic [47:0] RND      = 48'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce_p,
  input  logic [29:0] a,
  input  logic [17:0] b,
  input  logic [47:0] c,
  input  logic [47:0] pcin,
  input  logic        carryin,
  input  logic [8:0]  opmode,
  input  logic [3:0]  alumode,
  output logic [47:0] p,
  output logic        carryout
);

  localparam int unsigned DW = 48;
  localparam int unsigned AW = DW + 1;
  localparam int unsigned MW = 45;

  logic [DW-1:0]        p_q;
  logic [DW-1:0]        p_d;
  logic                 co_q;
  logic                 co_d;
  logic [DW-1:0]        p_fb;
  logic signed [MW-1:0] a_ext;
  logic signed [MW-1:0] b_ext;
  logic signed [MW-1:0] m_prod;
  logic [DW-1:0]        m_full;
  logic [1:0]           x_sel;
  logic [1:0]           y_sel;
  logic [2:0]           z_sel;
  logic [1:0]           w_sel;
  logic [DW-1:0]        x_mux;
  logic [DW-1:0]        y_mux;
  logic [DW-1:0]        z_mux;
  logic [DW-1:0]        w_mux;
  logic [DW-1:0]        logic_res;
  logic [AW-1:0]        s_sum;
  logic [AW-1:0]        z_ext;
  logic [AW-1:0]        alu_res;
  logic                 alu_co;

  assign x_sel = opmode[1:0];
  assign y_sel = opmode[3:2];
  assign z_sel = opmode[6:4];
  assign w_sel = opmode[8:7];

  // Without a P register, P feedback reads zero so no combinational loop forms.
  assign p_fb = (PREG != 0) ? p_q : '0;

  assign a_ext  = MW'($signed(a[26:0]));
  assign b_ext  = MW'($signed(b));
  assign m_prod = a_ext * b_ext;
  assign m_full = (USE_MULT != 0) ? DW'(m_prod) : '0;

  // Operand muxes; M is only contributed once, through X, when both X and Y select it.
  always_comb begin
    x_mux = '0;
    y_mux = '0;
    z_mux = '0;
    w_mux = '0;
    case (x_sel)
      2'b01:   x_mux = (y_sel == 2'b01) ? m_full : '0;
      2'b10:   x_mux = p_fb;
      2'b11:   x_mux = {a, b};
      default: x_mux = '0;
    endcase
    case (y_sel)
      2'b10:   y_mux = '1;
      2'b11:   y_mux = c;
      default: y_mux = '0;
    endcase
    case (z_sel)
      3'b001:         z_mux = pcin;
      3'b010, 3'b100: z_mux = p_fb;
      3'b011:         z_mux = c;
      3'b101:         z_mux = DW'($signed(pcin) >>> 17);
      3'b110:         z_mux = DW'($signed(p_fb) >>> 17);
      default:        z_mux = '0;
    endcase
    case (w_sel)
      2'b01:   w_mux = p_fb;
      2'b10:   w_mux = RND;
      2'b11:   w_mux = c;
      default: w_mux = '0;
    endcase
  end

  // Two-input logic unit; Y=all-ones flips each function to its dual.
  always_comb begin
    logic_res = '0;
    if (y_sel == 2'b00) begin
      case (alumode)
        4'b0100, 4'b0110: logic_res = x_mux ^ z_mux;
        4'b0101, 4'b0111: logic_res = ~(x_mux ^ z_mux);
        4'b1100:          logic_res = x_mux & z_mux;
        4'b1101:          logic_res = x_mux & ~z_mux;
        4'b1110:          logic_res = ~(x_mux & z_mux);
        4'b1111:          logic_res = ~x_mux | z_mux;
        default:          logic_res = '0;
      endcase
    end else if (y_sel == 2'b10) begin
      case (alumode)
        4'b0100, 4'b0110: logic_res = ~(x_mux ^ z_mux);
        4'b0101, 4'b0111: logic_res = x_mux ^ z_mux;
        4'b1100:          logic_res = x_mux | z_mux;
        4'b1101:          logic_res = x_mux | ~z_mux;
        4'b1110:          logic_res = ~(x_mux | z_mux);
        4'b1111:          logic_res = ~x_mux & z_mux;
        default:          logic_res = '0;
      endcase
    end
  end

  assign s_sum = AW'(w_mux) + AW'(x_mux) + AW'(y_mux) + AW'(carryin);
  assign z_ext = AW'(z_mux);

  always_comb begin
    alu_res = '0;
    alu_co  = 1'b0;
    case (alumode)
      4'b0000: begin
        alu_res = z_ext + s_sum;
        alu_co  = alu_res[DW];
      end
      4'b0011: begin
        alu_res = z_ext - s_sum;
        alu_co  = alu_res[DW];
      end
      4'b0001: alu_res = s_sum - z_ext - AW'(1);
      4'b0010: alu_res = ~(z_ext + s_sum);
      4'b0100, 4'b0101, 4'b0110, 4'b0111,
      4'b1100, 4'b1101, 4'b1110, 4'b1111: alu_res = AW'(logic_res);
      default: alu_res = '0;
    endcase
  end

  assign p_d  = alu_res[DW-1:0];
  assign co_d = alu_co;

  always_ff @(posedge clock) begin
    if (reset) begin
      p_q  <= '0;
      co_q <= 1'b0;
    end else if (ce_p) begin
      p_q  <= p_d;
      co_q <= co_d;
    end
  end

  assign p        = (PREG != 0) ? p_q  : p_d;
  assign carryout = (PREG != 0) ? co_q : co_d;

endmodule

// File: tb/tb_dsp48e2_alu_model.sv
// Bench for dsp48e2_alu_model: directed literal cases plus randomized traffic against
// an arithmetic reference model, over combinational, registered and no-multiplier builds.
module tb_dsp48e2_alu_model;

  localparam logic [47:0]     RNDV = 48'h0123_4567_89AB;
  localparam longint unsigned M48  = 64'h0000_FFFF_FFFF_FFFF;
  localparam longint unsigned M49  = 64'h0001_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_p;
  logic [29:0] a;
  logic [17:0] b;
  logic [47:0] c;
  logic [47:0] pcin;
  logic        carryin;
  logic [8:0]  opmode;
  logic [3:0]  alumode;
  logic [47:0] p0, p1, p2;
  logic        co0, co1, co2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp48e2_alu_model #(.PREG(0), .USE_MULT(1), .RND(RNDV)) dut0 (
    .clock(clk), .reset(reset), .ce_p(ce_p), .a(a), .b(b), .c(c), .pcin(pcin),
    .carryin(carryin), .opmode(opmode), .alumode(alumode), .p(p0), .carryout(co0));

  dsp48e2_alu_model #(.PREG(1), .USE_MULT(1), .RND(RNDV)) dut1 (
    .clock(clk), .reset(reset), .ce_p(ce_p), .a(a), .b(b), .c(c), .pcin(pcin),
    .carryin(carryin), .opmode(opmode), .alumode(alumode), .p(p1), .carryout(co1));

  dsp48e2_alu_model #(.PREG(0), .USE_MULT(0), .RND(RNDV)) dut2 (
    .clock(clk), .reset(reset), .ce_p(ce_p), .a(a), .b(b), .c(c), .pcin(pcin),
    .carryin(carryin), .opmode(opmode), .alumode(alumode), .p(p2), .carryout(co2));

  task automatic chk48(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: returns {carryout, p} from the operand/ALU rules using 64-bit integer arithmetic.
  function automatic logic [48:0] ref_out(input logic [29:0] ai, input logic [17:0] bi,
                                          input logic [47:0] ci, input logic [47:0] pi,
                                          input logic cin, input logic [8:0] op,
                                          input logic [3:0] alu, input logic [47:0] pfb,
                                          input bit mult_on);
    longint signed   prod;
    longint unsigned xv, yv, zv, wv, s, r, res;
    logic            co;
    logic [3:0]      tt;
    bit              lg;
    prod = longint'($signed(ai[26:0])) * longint'($signed(bi));
    xv = 0; yv = 0; zv = 0; wv = 0; res = 0; co = 1'b0; tt = 4'h0; lg = 1'b1;
    case (op[1:0])
      2'd1:    xv = (op[3:2] == 2'd1 && mult_on) ? (64'(prod) & M48) : 64'd0;
      2'd2:    xv = 64'(pfb);
      2'd3:    xv = 64'({ai, bi});
      default: xv = 0;
    endcase
    case (op[3:2])
      2'd2:    yv = M48;
      2'd3:    yv = 64'(ci);
      default: yv = 0;
    endcase
    case (op[6:4])
      3'd1:       zv = 64'(pi);
      3'd2, 3'd4: zv = 64'(pfb);
      3'd3:       zv = 64'(ci);
      3'd5:       zv = 64'(longint'($signed(pi)) >>> 17) & M48;
      3'd6:       zv = 64'(longint'($signed(pfb)) >>> 17) & M48;
      default:    zv = 0;
    endcase
    case (op[8:7])
      2'd1:    wv = 64'(pfb);
      2'd2:    wv = 64'(RNDV);
      2'd3:    wv = 64'(ci);
      default: wv = 0;
    endcase
    s = (wv + xv + yv + 64'(cin)) & M49;
    case (alu)
      4'h0: begin r = (zv + s) & M49; res = r & M48; co = r[48]; end
      4'h3: begin r = (zv - s) & M49; res = r & M48; co = r[48]; end
      4'h1: res = (s - zv - 64'd1) & M48;
      4'h2: res = ~(zv + s) & M48;
      default: begin
        // Truth tables indexed by {x_bit, z_bit}.
        if (op[3:2] == 2'd0) begin
          case (alu)
            4'h4, 4'h6: tt = 4'h6;
            4'h5, 4'h7: tt = 4'h9;
            4'hC:       tt = 4'h8;
            4'hD:       tt = 4'h4;
            4'hE:       tt = 4'h7;
            4'hF:       tt = 4'hB;
            default:    lg = 1'b0;
          endcase
        end else if (op[3:2] == 2'd2) begin
          case (alu)
            4'h4, 4'h6: tt = 4'h9;
            4'h5, 4'h7: tt = 4'h6;
            4'hC:       tt = 4'hE;
            4'hD:       tt = 4'hD;
            4'hE:       tt = 4'h1;
            4'hF:       tt = 4'h2;
            default:    lg = 1'b0;
          endcase
        end else begin
          lg = 1'b0;
        end
        if (lg) begin
          for (int i = 0; i < 48; i++) res[i] = tt[{xv[i], zv[i]}];
        end
      end
    endcase
    return {co, res[47:0]};
  endfunction

  logic [47:0] mp1 = '0;
  logic        mco1 = 1'b0;
  bit          armed = 1'b0;

  // Cycle-by-cycle comparison of all three builds against the reference.
  always @(posedge clk) begin
    logic [48:0] nxt;
    logic [48:0] e0;
    logic [48:0] e2;
    nxt = ref_out(a, b, c, pcin, carryin, opmode, alumode, mp1, 1'b1);
    if (reset) begin
      mp1   = '0;
      mco1  = 1'b0;
      armed = 1'b1;
    end else if (ce_p) begin
      mp1  = nxt[47:0];
      mco1 = nxt[48];
    end
    #1;
    e0 = ref_out(a, b, c, pcin, carryin, opmode, alumode, 48'h0, 1'b1);
    e2 = ref_out(a, b, c, pcin, carryin, opmode, alumode, 48'h0, 1'b0);
    if (armed) begin
      chk48("model_preg1_p", p1, mp1);
      chk1("model_preg1_co", co1, mco1);
    end
    chk48("model_comb_p", p0, e0[47:0]);
    chk1("model_comb_co", co0, e0[48]);
    chk48("model_nomult_p", p2, e2[47:0]);
    chk1("model_nomult_co", co2, e2[48]);
  end

  initial begin
    reset = 1'b1; ce_p = 1'b0; a = '0; b = '0; c = '0; pcin = '0;
    carryin = 1'b0; opmode = '0; alumode = '0;
    @(negedge clk);
    reset = 1'b0;
    chk48("reset_p", p1, 48'h0);
    chk1("reset_co", co1, 1'b0);

    opmode = 9'b000111011; alumode = 4'b1110; a = '0; b = 18'h000F0; c = 48'hFF;
    #1 chk48("nor_p", p0, 48'hFFFF_FFFF_FF00);
    chk1("nor_co", co0, 1'b0);

    @(negedge clk);
    opmode = 9'b000110011; alumode = 4'b0000; b = 18'd5; c = 48'd7; carryin = 1'b1;
    #1 chk48("add_p", p0, 48'd13);
    chk1("add_co", co0, 1'b0);

    @(negedge clk);
    c = '1; b = 18'd1; carryin = 1'b0;
    #1 chk48("add_wrap_p", p0, 48'h0);
    chk1("add_wrap_co", co0, 1'b1);

    @(negedge clk);
    alumode = 4'b0011; c = 48'd10; b = 18'd3;
    #1 chk48("sub_p", p0, 48'd7);

    @(negedge clk);
    opmode = 9'b000000101; alumode = 4'b0000; a = 30'h3FFF_FFFD; b = 18'd4; c = '0; ce_p = 1'b1;
    #1 chk48("mult_comb_p", p0, 48'hFFFF_FFFF_FFF4);
    chk48("mult_off_p", p2, 48'h0);
    @(posedge clk);
    #2 chk48("mult_reg_p", p1, 48'hFFFF_FFFF_FFF4);

    @(negedge clk);
    reset = 1'b1; ce_p = 1'b0;
    @(negedge clk);
    reset = 1'b0; opmode = 9'b000100011; alumode = 4'b0000; a = '0; b = 18'd1; ce_p = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #2 chk48("acc_p", p1, 48'(k));
    end
    @(negedge clk);
    ce_p = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk48("acc_hold_p", p1, 48'd4);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2 chk48("acc_reset_p", p1, 48'h0);

    @(negedge clk);
    reset = 1'b0; ce_p = 1'b1; b = 18'd5;
    @(posedge clk);
    #2 chk48("pre_prio_p", p1, 48'd5);
    @(negedge clk);
    reset = 1'b1; c = 48'h1234; opmode = 9'b000110011;
    @(posedge clk);
    #2 chk48("reset_prio_p", p1, 48'h0);
    chk1("reset_prio_co", co1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a       = 30'($urandom);
      b       = 18'($urandom);
      c       = ($urandom_range(0, 7) == 0) ? '1 : 48'({$urandom, $urandom});
      pcin    = 48'({$urandom, $urandom});
      carryin = 1'($urandom);
      opmode  = 9'($urandom);
      alumode = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      ce_p    = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
